tq_fdct_4x4_seq: RTL and testbench

//  Forward 4x4 H.264 integer core transform, Y = H*X*H^T, with no scaling (the quantiser owns scaling).
//  Row-serial residual input, column-serial coefficient output, valid/ready on both sides.

---
 rtl/tq_pkg.sv | 18 +
 rtl/tq_fdct4_1d.sv | 26 ++
 rtl/tq_fdct_4x4_seq.sv | 111 +++++++++++
 tb/tb_tq_fdct_4x4_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tq_pkg.sv
// Shared widths, row/column types and read-side FSM states for the 4x4
// forward core transform.
package tq_pkg;

  localparam int unsigned RES_W  = 9;
  localparam int unsigned MID_W  = RES_W + 3;
  localparam int unsigned COEF_W = MID_W + 3;

  typedef logic [3:0][RES_W-1:0]  res_row_t;
  typedef logic [3:0][MID_W-1:0]  mid_row_t;
  typedef logic [3:0][COEF_W-1:0] coef_col_t;

  typedef enum logic {
    RD_IDLE,
    RD_DRAIN
  } rd_state_t;

endpackage

// File: rtl/tq_fdct4_1d.sv
// Combinational 1-D H.264 forward butterfly: 4 x IN_W signed in,
// 4 x (IN_W+3) signed out.
module tq_fdct4_1d #(
  parameter int unsigned IN_W = 9
) (
  input  logic [4*IN_W-1:0]     x,
  output logic [4*(IN_W+3)-1:0] y
);

  localparam int unsigned OUT_W = IN_W + 3;

  logic signed [OUT_W-1:0] xe [4];
  logic signed [OUT_W-1:0] a0, a1, a2, a3;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      xe[i] = {{3{x[i*IN_W+IN_W-1]}}, x[i*IN_W +: IN_W]};
    end
    a0 = xe[0] + xe[3];
    a1 = xe[1] + xe[2];
    a2 = xe[1] - xe[2];
    a3 = xe[0] - xe[3];
    y  = {a3 - (a2 <<< 1), a0 - a1, (a3 <<< 1) + a2, a0 + a1};
  end

endmodule

// File: rtl/tq_fdct_4x4_seq.sv
// Row-serial in / column-serial out 4x4 forward integer transform with a
// double-banked transpose buffer between the horizontal and vertical passes.
module tq_fdct_4x4_seq
  import tq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [4*RES_W-1:0]  in_row_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [4*COEF_W-1:0] out_col_o,
  output logic [1:0]          out_idx_o,
  output logic                out_last_o
);

  mid_row_t  h_row;
  mid_row_t  v_in;
  coef_col_t v_col;
  mid_row_t  bank [2][4];

  logic [1:0] full, full_nxt;
  logic       wr_bank, rd_bank, rd_bank_nxt;
  logic [1:0] wr_row, rd_col;
  rd_state_t  rd_state;
  logic       in_fire, bypass, load;

  assign in_ready_o = ~full[wr_bank];
  assign in_fire    = in_valid_i & in_ready_o;
  // Row 3 arriving into the bank being read feeds column 0 directly, so the
  // first column is presented the cycle after the block completes.
  assign bypass     = in_fire & (wr_row == 2'd3) & (wr_bank == rd_bank);
  assign load       = ((rd_state == RD_DRAIN) | bypass) & (~out_valid_o | out_ready_i);

  tq_fdct4_1d #(.IN_W(RES_W)) u_hpass (
    .x (in_row_i),
    .y (h_row)
  );

  tq_fdct4_1d #(.IN_W(MID_W)) u_vpass (
    .x (v_in),
    .y (v_col)
  );

  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      v_in[r] = bank[rd_bank][r][rd_col];
    end
    if (bypass) v_in[3] = h_row[rd_col];
  end

  always_comb begin
    full_nxt    = full;
    rd_bank_nxt = rd_bank;
    if (in_fire && wr_row == 2'd3) full_nxt[wr_bank] = 1'b1;
    if (load && rd_col == 2'd3) begin
      full_nxt[rd_bank] = 1'b0;
      rd_bank_nxt       = ~rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire && !flush_i) bank[wr_bank][wr_row] <= h_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full        <= '0;
      wr_bank     <= 1'b0;
      wr_row      <= '0;
      rd_bank     <= 1'b0;
      rd_col      <= '0;
      rd_state    <= RD_IDLE;
      out_valid_o <= 1'b0;
      out_col_o   <= '0;
      out_idx_o   <= '0;
      out_last_o  <= 1'b0;
    end else if (flush_i) begin
      full        <= '0;
      wr_bank     <= 1'b0;
      wr_row      <= '0;
      rd_bank     <= 1'b0;
      rd_col      <= '0;
      rd_state    <= RD_IDLE;
      out_valid_o <= 1'b0;
      out_col_o   <= '0;
      out_idx_o   <= '0;
      out_last_o  <= 1'b0;
    end else begin
      full     <= full_nxt;
      rd_bank  <= rd_bank_nxt;
      rd_state <= full_nxt[rd_bank_nxt] ? RD_DRAIN : RD_IDLE;
      if (in_fire) begin
        wr_row <= wr_row + 2'd1;
        if (wr_row == 2'd3) wr_bank <= ~wr_bank;
      end
      if (load) begin
        out_valid_o <= 1'b1;
        out_col_o   <= v_col;
        out_idx_o   <= rd_col;
        out_last_o  <= (rd_col == 2'd3);
        rd_col      <= rd_col + 2'd1;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tq_fdct_4x4_seq.sv
// Scoreboard bench for tq_fdct_4x4_seq: stimulus pushes expected columns,
// an independent monitor pops and compares on every output handshake.
module tb_tq_fdct_4x4_seq;
  import tq_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n, flush_i, in_valid_i, in_ready_o;
  logic [4*RES_W-1:0]  in_row_i;
  logic                out_valid_o, out_ready_i, out_last_o;
  logic [4*COEF_W-1:0] out_col_o;
  logic [1:0]          out_idx_o;

  always #5 clk = ~clk;

  tq_fdct_4x4_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_row_i    (in_row_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_col_o   (out_col_o),
    .out_idx_o   (out_idx_o),
    .out_last_o  (out_last_o)
  );

  typedef struct {
    int y0, y1, y2, y3, idx, last;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   ev_cycles[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   stall_waits = 0;
  int   blk [4][4];
  logic [4*COEF_W-1:0] snap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int coef(input int i);
    logic signed [COEF_W-1:0] v;
    v = out_col_o[i*COEF_W +: COEF_W];
    return int'(v);
  endfunction

  // Monitor: one comparison per consumed column.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      ev_cycles.push_back(cyc + 1);
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL col_unexpected: got idx %0d with no column expected", out_idx_o);
      end else begin
        mon_e = sbq.pop_front();
        if (coef(0) != mon_e.y0 || coef(1) != mon_e.y1 || coef(2) != mon_e.y2 ||
            coef(3) != mon_e.y3 || int'(out_idx_o) != mon_e.idx || int'(out_last_o) != mon_e.last) begin
          n_bad++;
          $display("FAIL col_k%0d: got (%0d,%0d,%0d,%0d) idx %0d last %0d expected (%0d,%0d,%0d,%0d) idx %0d last %0d",
                   mon_e.idx, coef(0), coef(1), coef(2), coef(3), out_idx_o, out_last_o,
                   mon_e.y0, mon_e.y1, mon_e.y2, mon_e.y3, mon_e.idx, mon_e.last);
        end
      end
    end
  end

  function automatic int pat(input int id, input int r, input int c);
    case (id)
      0:       return 255;
      1:       return (r == 0 && c == 0) ? 1 : 0;
      2:       return ((r + c) % 2 == 0) ? 255 : -255;
      3:       return (r * 4 + c) * 31 - 240;
      4:       return -255;
      5:       return ((r * 7 + c * 13) % 11) * 50 - 250;
      default: return (r == c) ? 255 : -(r + 1) * c * 20;
    endcase
  endfunction

  function automatic int hm(input int i, input int j);
    case (i)
      0:       return 1;
      1:       return (j == 0) ? 2 : (j == 1) ? 1 : (j == 2) ? -1 : -2;
      2:       return (j == 0 || j == 3) ? 1 : -1;
      default: return (j == 0) ? 1 : (j == 1) ? -2 : (j == 2) ? 2 : -1;
    endcase
  endfunction

  task automatic load_pat(input int id);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        blk[r][c] = pat(id, r, c);
  endtask

  task automatic push_col(input int y0, input int y1, input int y2, input int y3, input int k);
    exp_t e;
    e.y0 = y0; e.y1 = y1; e.y2 = y2; e.y3 = y3; e.idx = k; e.last = (k == 3) ? 1 : 0;
    sbq.push_back(e);
  endtask

  // Reference: Y = H * X * H^T by direct matrix sums.
  task automatic push_model();
    int y [4];
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        y[i] = 0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            y[i] += hm(i, r) * blk[r][c] * hm(k, c);
      end
      push_col(y[0], y[1], y[2], y[3], k);
    end
  endtask

  task automatic send_rows(input int nrows);
    int w;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < 4; c++) in_row_i[c*RES_W +: RES_W] = RES_W'(blk[r][c]);
      in_valid_i = 1'b1;
      w = 0;
      while (1) begin
        @(negedge clk);
        if (in_ready_o) break;
        w++;
        if (w > 300) begin
          $display("FAIL row_accept_timeout: row %0d not accepted after %0d cycles", r, w);
          $fatal(1, "row accept timeout");
        end
      end
      if (w > 0) stall_waits++;
      last_acc = cyc + 1;
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sbq.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("sb_drained", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid_o), 0);
    chk({tag, "_out_col_zero"}, int'(out_col_o == '0), 1);
    chk({tag, "_out_idx"}, int'(out_idx_o), 0);
    chk({tag, "_out_last"}, int'(out_last_o), 0);
    chk({tag, "_in_ready"}, int'(in_ready_o), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_row_i = '0; out_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: flat 255 block
    load_pat(0);
    push_col(4080, 0, 0, 0, 0); push_col(0, 0, 0, 0, 1);
    push_col(0, 0, 0, 0, 2);    push_col(0, 0, 0, 0, 3);
    send_rows(4);
    wait_drain();

    // 2: impulse
    load_pat(1);
    push_col(1, 2, 1, 1, 0); push_col(2, 4, 2, 2, 1);
    push_col(1, 2, 1, 1, 2); push_col(1, 2, 1, 1, 3);
    send_rows(4);
    wait_drain();

    // 3: checkerboard, largest coefficient 9180
    load_pat(2);
    push_col(0, 0, 0, 0, 0);    push_col(0, 1020, 0, 3060, 1);
    push_col(0, 0, 0, 0, 2);    push_col(0, 3060, 0, 9180, 3);
    send_rows(4);
    wait_drain();

    // 4: three blocks back-to-back
    ev_cycles.delete();
    stall_waits = 0;
    t0 = 0;
    for (int b = 3; b <= 5; b++) begin
      load_pat(b);
      push_model();
      send_rows(4);
      if (b == 3) t0 = last_acc;
    end
    chk("t4_ready_waits", stall_waits, 0);
    wait_drain();
    chk("t4_col_count", ev_cycles.size(), 12);
    for (int j = 0; j < 12 && j < ev_cycles.size(); j++)
      chk($sformatf("t4_col%0d_cycle", j), ev_cycles[j], t0 + 1 + j);

    // 5: output stalled while feeding two blocks, then released
    out_ready_i = 1'b0;
    load_pat(5); push_model(); send_rows(4);
    load_pat(6); push_model(); send_rows(4);
    @(negedge clk);
    chk("t5_ready_low", int'(in_ready_o), 0);
    chk("t5_valid_held", int'(out_valid_o), 1);
    snap = out_col_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", int'(out_valid_o), 1);
      chk("t5_hold_col", int'(out_col_o == snap), 1);
      chk("t5_hold_idx", int'(out_idx_o), 0);
      chk("t5_ready_still_low", int'(in_ready_o), 0);
    end
    load_pat(3); push_model();
    @(posedge clk); #1 out_ready_i = 1'b1;
    send_rows(4);
    wait_drain();

    // 6: reset, then flush, with stored and partial blocks discarded
    out_ready_i = 1'b0;
    load_pat(4); send_rows(4);
    load_pat(5); send_rows(2);
    @(negedge clk);
    chk("t6_pre_valid", int'(out_valid_o), 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t6_rst");
    @(posedge clk); #1 rst_n = 1'b1; out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_rst_no_spurious", int'(out_valid_o), 0);
    end
    @(posedge clk); #1 out_ready_i = 1'b0;
    load_pat(4); send_rows(4);
    load_pat(5); send_rows(2);
    flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t6_flush");
    @(posedge clk); #1 out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_flush_no_spurious", int'(out_valid_o), 0);
    end
    @(posedge clk); #1;
    load_pat(6); push_model(); send_rows(4);
    wait_drain();

    repeat (4) @(negedge clk);
    chk("final_sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
